// File: rtl/mem_ctrl_pkg.sv
// Shared types, widths and helpers for the mem_ctrl block-transfer controller.
// Width macros PA_WIDTH, BLK_WIDTH and BYTE may be predefined by the build; defaults are given here.
`ifndef PA_WIDTH
`define PA_WIDTH 32
`endif
`ifndef BLK_WIDTH
`define BLK_WIDTH 512
`endif
`ifndef BYTE
`define BYTE 8
`endif

package mem_ctrl_pkg;

    localparam int PA_WIDTH  = `PA_WIDTH;
    localparam int BLK_WIDTH = `BLK_WIDTH;
    localparam int BYTE_W    = `BYTE;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        OP_READ       = 2'b00,
        OP_WRITE      = 2'b01,
        OP_EVICT_FILL = 2'b10,
        OP_ILLEGAL    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB      = 3'd1,
        ST_WAIT_WB = 3'd2,
        ST_RD      = 3'd3,
        ST_WAIT_RD = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    function automatic int off_bits_calc(input int blk_width, input int byte_width);
        return $clog2(blk_width / byte_width);
    endfunction

    localparam int DEF_OFF_BITS = off_bits_calc(BLK_WIDTH, BYTE_W);

    // Clears the block-offset bits so every array access is block aligned.
    function automatic logic [PA_WIDTH-1:0] blk_align(input logic [PA_WIDTH-1:0] addr, input int off_bits);
        logic [PA_WIDTH-1:0] mask;
        mask = {PA_WIDTH{1'b1}} << off_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_ctrl_lat_cnt.sv
// Loadable 8-bit down-counter timing the memory wait states; stops at zero.
module mem_ctrl_lat_cnt
    import mem_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Load has priority over counting; counting halts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding block-transfer controller between cache and main-memory array.
// Optional strobe statistics counters enabled by defining MEM_CTRL_STATS_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT  = 4,
    parameter int OFF_BITS = DEF_OFF_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [PA_WIDTH-1:0]  req_addr,
    input  logic [PA_WIDTH-1:0]  req_victim_addr,
    input  logic [BLK_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BLK_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_data,
    input  logic [BLK_WIDTH-1:0] mem_rd_data
`ifdef MEM_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_rd_cnt,
    output logic [31:0]          stat_wr_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e               state_r, state_nxt_s;
    op_e                  op_r, req_op_s;
    logic [PA_WIDTH-1:0]  fill_addr_r, mem_addr_r;
    logic [BLK_WIDTH-1:0] mem_wr_data_r, resp_rdata_r;
    logic                 idle_r, mem_rd_en_r, mem_wr_en_r, resp_valid_r, resp_err_r;
    logic                 accept_s, cnt_load_s, cnt_en_s, cnt_zero_s;
    logic                 rd_en_nxt_s, wr_en_nxt_s, resp_valid_nxt_s, idle_nxt_s;

    assign req_op_s  = op_e'(req_op);
    // idle_r comes out of reset high; gating with rst_n keeps req_ready low during reset.
    assign req_ready = idle_r & rst_n;
    assign accept_s  = req_valid & req_ready;

    mem_ctrl_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .en       (cnt_en_s),
        .load_val (LAT_LOAD),
        .zero     (cnt_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (req_op_s)
                        OP_READ:       state_nxt_s = ST_RD;
                        OP_WRITE:      state_nxt_s = ST_WB;
                        OP_EVICT_FILL: state_nxt_s = ST_WB;
                        default:       state_nxt_s = ST_RESP;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB:      state_nxt_s = ST_WAIT_WB;
            ST_WAIT_WB: begin
                if (cnt_zero_s) begin
                    state_nxt_s = (op_r == OP_EVICT_FILL) ? ST_RD : ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT_WB;
                end
            end
            ST_RD:      state_nxt_s = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT_RD;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so strobes and flags come straight from flops.
    always_comb begin
        rd_en_nxt_s      = (state_nxt_s == ST_RD);
        wr_en_nxt_s      = (state_nxt_s == ST_WB);
        resp_valid_nxt_s = (state_nxt_s == ST_RESP);
        idle_nxt_s       = (state_nxt_s == ST_IDLE);
        cnt_load_s       = ((state_nxt_s == ST_WAIT_WB) && (state_r != ST_WAIT_WB)) ||
                           ((state_nxt_s == ST_WAIT_RD) && (state_r != ST_WAIT_RD));
        cnt_en_s         = (state_r == ST_WAIT_WB) || (state_r == ST_WAIT_RD);
    end

    // Output registers and request capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_r        <= 1'b1;
            mem_rd_en_r   <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_err_r    <= 1'b0;
            op_r          <= OP_READ;
            fill_addr_r   <= {PA_WIDTH{1'b0}};
            mem_addr_r    <= {PA_WIDTH{1'b0}};
            mem_wr_data_r <= {BLK_WIDTH{1'b0}};
            resp_rdata_r  <= {BLK_WIDTH{1'b0}};
        end else begin
            idle_r       <= idle_nxt_s;
            mem_rd_en_r  <= rd_en_nxt_s;
            mem_wr_en_r  <= wr_en_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            if (accept_s) begin
                op_r         <= req_op_s;
                fill_addr_r  <= blk_align(req_addr, OFF_BITS);
                resp_rdata_r <= {BLK_WIDTH{1'b0}};
                resp_err_r   <= (req_op_s == OP_ILLEGAL);
                // The first access address is staged now since WB/RD follow immediately.
                if (req_op_s == OP_EVICT_FILL) begin
                    mem_addr_r <= blk_align(req_victim_addr, OFF_BITS);
                end else if (req_op_s != OP_ILLEGAL) begin
                    mem_addr_r <= blk_align(req_addr, OFF_BITS);
                end
                if ((req_op_s == OP_WRITE) || (req_op_s == OP_EVICT_FILL)) begin
                    mem_wr_data_r <= req_wdata;
                end
            end else begin
                if ((state_r == ST_WAIT_WB) && (state_nxt_s == ST_RD)) begin
                    mem_addr_r <= fill_addr_r;
                end
                if ((state_r == ST_WAIT_RD) && cnt_zero_s) begin
                    resp_rdata_r <= mem_rd_data;
                end
            end
        end
    end

    assign mem_rd_en   = mem_rd_en_r;
    assign mem_wr_en   = mem_wr_en_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wr_data = mem_wr_data_r;
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = resp_rdata_r;
    assign resp_err    = resp_err_r;

`ifdef MEM_CTRL_STATS_EN
    logic [31:0] stat_rd_r, stat_wr_r;

    // Saturating strobe counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_r <= 32'd0;
            stat_wr_r <= 32'd0;
        end else begin
            if (mem_rd_en_r && (stat_rd_r != 32'hFFFF_FFFF)) begin
                stat_rd_r <= stat_rd_r + 32'd1;
            end
            if (mem_wr_en_r && (stat_wr_r != 32'hFFFF_FFFF)) begin
                stat_wr_r <= stat_wr_r + 32'd1;
            end
        end
    end

    assign stat_rd_cnt = stat_rd_r;
    assign stat_wr_cnt = stat_wr_r;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl (MEM_LAT=4, 32-bit addresses, 512-bit blocks).
module tb_mem_ctrl;

    typedef struct {
        logic [511:0] rdata;
        logic         err;
        int           first_cyc;
    } resp_t;

    typedef struct {
        logic         is_wr;
        logic [31:0]  addr;
        logic [511:0] data;
        int           cyc;
    } strobe_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [31:0]  req_addr = 32'd0;
    logic [31:0]  req_victim_addr = 32'd0;
    logic [511:0] req_wdata = 512'd0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [511:0] resp_rdata;
    logic         resp_err;
    logic [31:0]  mem_addr;
    logic         mem_rd_en;
    logic         mem_wr_en;
    logic [511:0] mem_wr_data;
    logic [511:0] mem_rd_data = 512'd0;
`ifdef MEM_CTRL_STATS_EN
    logic [31:0]  stat_rd_cnt;
    logic [31:0]  stat_wr_cnt;
`endif

    int total = 0;
    int passed = 0;
    int cyc = 0;

    resp_t   resp_q[$];
    strobe_t strb_q[$];
    logic [511:0] mem [logic [31:0]];

    logic [511:0] pat_p, pat_d, pat_v, pat_f;
    logic         prev_valid = 1'b0;
    logic [511:0] prev_rdata = 512'd0;
    logic         prev_err = 1'b0;

    mem_ctrl #(.MEM_LAT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_victim_addr (req_victim_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_addr        (mem_addr),
        .mem_rd_en       (mem_rd_en),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_data     (mem_wr_data),
        .mem_rd_data     (mem_rd_data)
`ifdef MEM_CTRL_STATS_EN
        ,
        .stat_rd_cnt     (stat_rd_cnt),
        .stat_wr_cnt     (stat_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory array model: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem.exists(mem_addr) ? mem[mem_addr] : 512'd0;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes memory or hands over a response.
    always @(negedge clk) begin : monitor
        strobe_t s;
        resp_t   r;
        if (rst_n) begin
            if (mem_rd_en && mem_wr_en) chk("strobe_exclusive", 1'b1, 1'b0);
            if (mem_rd_en || mem_wr_en) begin
                if (strb_q.size() == 0) begin
                    chk("unexpected_strobe", {mem_wr_en, mem_rd_en}, 2'b00);
                end else begin
                    s = strb_q.pop_front();
                    chk("strobe_kind", mem_wr_en, s.is_wr);
                    chk("strobe_addr", mem_addr, s.addr);
                    chk("strobe_cycle", cyc, s.cyc);
                    if (s.is_wr) chk("strobe_wdata", mem_wr_data, s.data);
                end
            end
            if (resp_valid) chk("req_ready_in_resp", req_ready, 1'b0);
            if (resp_valid && prev_valid) begin
                chk("resp_rdata_stable", resp_rdata, prev_rdata);
                chk("resp_err_stable", resp_err, prev_err);
            end
            if (resp_valid && !prev_valid) begin
                if (resp_q.size() == 0) chk("unexpected_resp", resp_valid, 1'b0);
                else chk("resp_latency", cyc, resp_q[0].first_cyc);
            end
            if (resp_valid && resp_ready && (resp_q.size() > 0)) begin
                r = resp_q.pop_front();
                chk("resp_rdata", resp_rdata, r.rdata);
                chk("resp_err", resp_err, r.err);
            end
        end
        prev_valid = resp_valid;
        prev_rdata = resp_rdata;
        prev_err   = resp_err;
    end

    // Called at a negedge; pushes hand-computed expectations, then performs the handshake.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] v,
                         input logic [511:0] wd, input logic [511:0] exp_rdata);
        int      n;
        int      h;
        resp_t   r;
        strobe_t s;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 1'b0, 1'b1);
            return;
        end
        h = cyc + 1;
        r.rdata = exp_rdata;
        r.err   = 1'b0;
        case (op)
            2'b00: begin
                s = '{1'b0, a & 32'hFFFF_FFC0, 512'd0, h};  strb_q.push_back(s);
                r.first_cyc = h + 5;
            end
            2'b01: begin
                s = '{1'b1, a & 32'hFFFF_FFC0, wd, h};      strb_q.push_back(s);
                r.first_cyc = h + 5;
            end
            2'b10: begin
                s = '{1'b1, v & 32'hFFFF_FFC0, wd, h};      strb_q.push_back(s);
                s = '{1'b0, a & 32'hFFFF_FFC0, 512'd0, h + 5}; strb_q.push_back(s);
                r.first_cyc = h + 10;
            end
            default: begin
                r.err = 1'b1;
                r.first_cyc = h;
            end
        endcase
        resp_q.push_back(r);
        req_valid = 1'b1;
        req_op = op;
        req_addr = a;
        req_victim_addr = v;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 512'd0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || strb_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", resp_q.size() + strb_q.size(), 0);
    endtask

    initial begin
        pat_p = {16{32'hDEAD_BEEF}};
        pat_d = {8{64'h0123_4567_89AB_CDEF}};
        pat_v = {16{32'h5A5A_C3C3}};
        pat_f = {64{8'h3C}};
        mem[32'h0001_2340] = pat_p;
        mem[32'h0000_0800] = pat_f;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_mem_rd_en", mem_rd_en, 1'b0);
        chk("rst_mem_wr_en", mem_wr_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 512'd0);
        chk("rst_resp_err", resp_err, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", req_ready, 1'b1);
        @(negedge clk);

        issue(2'b00, 32'h0001_234F, 32'd0, 512'd0, pat_p);
        wait_drain();
        issue(2'b01, 32'h0000_0080, 32'd0, pat_d, 512'd0);
        wait_drain();

        // Consumer stalls for 10 cycles after the response appears.
        resp_ready = 1'b0;
        issue(2'b00, 32'h0000_0080, 32'd0, 512'd0, pat_d);
        repeat (15) @(negedge clk);
        chk("stall_resp_valid", resp_valid, 1'b1);
        resp_ready = 1'b1;
        wait_drain();

        issue(2'b10, 32'h0000_0800, 32'h0000_0400, pat_v, pat_f);
        wait_drain();
        issue(2'b00, 32'h0000_0400, 32'd0, 512'd0, pat_v);
        wait_drain();
        issue(2'b11, 32'h0000_1000, 32'd0, pat_d, 512'd0);
        wait_drain();

        // Abort a READ while it sits in WAIT_RD.
        issue(2'b00, 32'h0001_2340, 32'd0, 512'd0, pat_p);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        resp_q.delete();
        strb_q.delete();
        #1;
        chk("abort_mem_rd_en", mem_rd_en, 1'b0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        chk("abort_req_ready", req_ready, 1'b0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_abort", req_ready, 1'b1);
`ifdef MEM_CTRL_STATS_EN
        chk("stat_rd_cnt_rst", stat_rd_cnt, 32'd0);
        chk("stat_wr_cnt_rst", stat_wr_cnt, 32'd0);
`endif
        repeat (20) @(negedge clk);

        issue(2'b00, 32'h0000_0800, 32'd0, 512'd0, pat_f);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Block-transfer controller directly upstream of the main-memory array. It accepts cache refill, writeback and evict-then-fill requests over a valid/ready handshake and drives the array's addr/rd_en/wr_en/wr_data. It models DRAM access time with a programmable wait and returns fill data over a valid/ready response channel. Exactly one transaction is in flight at a time.

Parameters:
MEM_LAT, 4, wait cycles after each memory enable pulse; legal range 1..255.
OFF_BITS, $clog2(BLK_WIDTH/BYTE), block-offset bits cleared on every memory address.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE and never while rst_n=0
req_op  in  2  00 READ, 01 WRITE, 10 EVICT_FILL, 11 illegal
req_addr  in  PA_WIDTH  fill address; write address for WRITE
req_victim_addr  in  PA_WIDTH  writeback address for EVICT_FILL
req_wdata  in  BLK_WIDTH  writeback block for WRITE and EVICT_FILL
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  BLK_WIDTH  fill data
resp_err  out  1  illegal op flag
mem_addr  out  PA_WIDTH  block-aligned array address
mem_rd_en  out  1  array read strobe
mem_wr_en  out  1  array write strobe
mem_wr_data  out  BLK_WIDTH  array write block
mem_rd_data  in  BLK_WIDTH  array read block; valid the cycle after mem_rd_en

Behaviour:
- Reset: all outputs 0, state IDLE, latency counter 0. rst_n falling mid-transaction aborts it immediately, with no response and no further strobes. mem_*_en drop asynchronously.
- Input capture: on the req_valid&&req_ready edge, latch op, both addresses and wdata. Addresses are stored with the low OFF_BITS cleared.
- States: IDLE, WB, WAIT_WB, RD, WAIT_RD, RESP.
- IDLE -> RD for READ; IDLE -> WB for WRITE or EVICT_FILL; IDLE -> RESP for op 11, with resp_err=1 and no memory access.
- WB: mem_wr_en=1 for exactly one cycle; mem_addr = req_addr for WRITE, req_victim_addr for EVICT_FILL; mem_wr_data = latched wdata. Then -> WAIT_WB.
- WAIT_WB: lasts MEM_LAT cycles, then -> RD for EVICT_FILL or -> RESP for WRITE.
- RD: mem_rd_en=1 for one cycle with mem_addr = fill address, then -> WAIT_RD.
- WAIT_RD: lasts MEM_LAT cycles; mem_rd_data is captured into resp_rdata on the last of these cycles, then -> RESP.
- RESP: resp_valid=1, with resp_rdata and resp_err held stable until resp_ready. -> IDLE on the handshake edge; resp_valid falls the next cycle.
- Response data: resp_rdata=0 for WRITE and illegal ops.
- Latency, handshake edge to first resp_valid cycle: READ and WRITE = MEM_LAT+2 cycles; EVICT_FILL = 2*MEM_LAT+3 cycles; illegal = 1 cycle.
- Back-to-back: a new request is accepted no earlier than the cycle after the response handshake, because req_ready=0 in RESP.
- Strobes are never both high. mem_addr and mem_wr_data hold their values outside the strobe cycles.
- Counter width is 8 bits; it loads MEM_LAT-1 on entry to a WAIT state and counts down to 0 with no wrap.

Optional Feature:
MEM_CTRL_STATS_EN
- Defined: adds outputs stat_rd_cnt[31:0] and stat_wr_cnt[31:0]. Each increments on its mem_rd_en / mem_wr_en strobe cycle, saturates at 32'hFFFFFFFF, and resets to 0 on rst_n.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_ctrl_pkg: op encoding enum (READ, WRITE, EVICT_FILL, ILLEGAL), state enum, and the OFF_BITS helper. It includes the existing width macros (PA_WIDTH, BLK_WIDTH, BYTE).
- Sub-module mem_ctrl_lat_cnt: a loadable 8-bit down-counter with load, enable and zero outputs, instanced once.

Test Plan:
- READ, MEM_LAT=4, BLK_WIDTH=512, req_addr=0x1234F, memory preloaded with pattern P at 0x12340 -> exactly one mem_rd_en at handshake+1 with mem_addr=0x12340; resp_valid at handshake+6; resp_rdata=P; resp_err=0.
- WRITE to 0x00080 with data D, then READ 0x00080 -> one mem_wr_en pulse with addr 0x00080 and data D; the READ returns D; no rd strobe during the WRITE.
- EVICT_FILL, victim 0x00400 with data V, fill 0x00800 holding F -> wr strobe at handshake+1 to 0x00400, rd strobe at handshake+6 to 0x00800, resp_valid at handshake+11 with F; a later READ of 0x00400 returns V.
- resp_ready held low for 10 cycles -> resp_valid and resp_rdata stay stable, req_ready stays 0, no strobes; release -> IDLE and next request accepted.
- req_op=11 -> resp_valid the cycle after the handshake, resp_err=1, resp_rdata=0, zero memory strobes.
- rst_n pulled low in WAIT_RD -> outputs 0 immediately, no response after release, req_ready=1 the first cycle rst_n is high; with MEM_CTRL_STATS_EN, counters read 0.
